// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute-facing bundle for the branch resolve queue.
// Latency: n/a (wiring only).
// Backpressure: full is advisory; pushes while full are dropped and flagged by the queue.
interface branch_resolve_queue_if #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 7,
    parameter int CNT_W = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             push;
    logic [IDX_W-1:0] push_idx;
    logic             push_pred;
    logic             resolve_valid;
    logic             resolve_taken;
    logic             full;
    logic [CW-1:0]    count;
    logic             pht_load;
    logic             pht_outcome;
    logic [IDX_W-1:0] pht_idx;
    logic             mispredict;
    logic             overflow;
    logic             underflow;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mp_cnt;

    // Fetch/execute side: drives pushes and resolves, observes queue state.
    modport master (
        output push, push_idx, push_pred, resolve_valid, resolve_taken,
        input  full, count, pht_load, pht_outcome, pht_idx, mispredict,
               overflow, underflow, br_cnt, mp_cnt
    );

    // Queue side.
    modport slave (
        input  push, push_idx, push_pred, resolve_valid, resolve_taken,
        output full, count, pht_load, pht_outcome, pht_idx, mispredict,
               overflow, underflow, br_cnt, mp_cnt
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; matches execute resolutions and emits PHT updates.
// Latency: 1 cycle from accepted resolve to pht_load/mispredict.
// Backpressure: none; push while full is dropped (sticky overflow), resolve while empty ignored (sticky underflow).
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 7,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_resolve_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Each entry holds {idx, pred}.
    logic [IDX_W:0]   mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic             pht_load;
    logic             pht_outcome;
    logic [IDX_W-1:0] pht_idx;
    logic             mispredict;
    logic             overflow;
    logic             underflow;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mp_cnt;

    logic             full;
    logic             empty;
    logic [IDX_W:0]   head_ent;
    logic             res_acc;
    logic             res_mp;
    logic             push_acc;
    logic [CW-1:0]    inc;
    logic [CW-1:0]    dec;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign head_ent = mem[head];
    assign res_acc  = bus.resolve_valid && !empty;
    assign res_mp   = res_acc && (head_ent[0] != bus.resolve_taken);
    // A push in the same cycle as a mispredict is on the wrong path.
    assign push_acc = bus.push && !full && !res_mp;
    assign inc      = {{(CW-1){1'b0}}, push_acc};
    assign dec      = {{(CW-1){1'b0}}, res_acc};

    // Entry storage; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[tail] <= {bus.push_idx, bus.push_pred};
        end
    end

    // Pointers and occupancy; a mispredict discards every in-flight entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (res_mp) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_acc) tail <= tail + 1'b1;
            if (res_acc)  head <= head + 1'b1;
            count <= count + inc - dec;
        end
    end

    // Registered PHT update strobe; all fields drop to zero when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pht_load    <= 1'b0;
            pht_outcome <= 1'b0;
            pht_idx     <= '0;
            mispredict  <= 1'b0;
        end else begin
            pht_load    <= res_acc;
            pht_outcome <= res_acc && bus.resolve_taken;
            pht_idx     <= res_acc ? head_ent[IDX_W:1] : '0;
            mispredict  <= res_mp;
        end
    end

    // Sticky error flags and saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            br_cnt    <= '0;
            mp_cnt    <= '0;
        end else begin
            if (bus.push && full)                 overflow  <= 1'b1;
            if (bus.resolve_valid && empty)       underflow <= 1'b1;
            if (res_acc && (br_cnt != '1))        br_cnt    <= br_cnt + 1'b1;
            if (res_mp && (mp_cnt != '1))         mp_cnt    <= mp_cnt + 1'b1;
        end
    end

    assign bus.full        = full;
    assign bus.count       = count;
    assign bus.pht_load    = pht_load;
    assign bus.pht_outcome = pht_outcome;
    assign bus.pht_idx     = pht_idx;
    assign bus.mispredict  = mispredict;
    assign bus.overflow    = overflow;
    assign bus.underflow   = underflow;
    assign bus.br_cnt      = br_cnt;
    assign bus.mp_cnt      = mp_cnt;
endmodule
